// File: rtl/lift_request_scheduler.sv
// Lift call scheduler: latches edge-detected floor calls and steers a registered
// target floor with an IDLE / SERVE_UP / SERVE_DOWN collective-control FSM.
module lift_request_scheduler #(
  parameter int NUM_FLOORS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [2:0]            current_floor,
  input  logic                  door_open,
  output logic [2:0]            req_floor,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_UP   = 2'd1,
    SERVE_DOWN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [2:0]            req_nxt;
  logic [NUM_FLOORS-1:0] btn_hist;
  logic [NUM_FLOORS-1:0] call_rise;
  logic [NUM_FLOORS-1:0] at_floor;
  logic [NUM_FLOORS-1:0] floor_clr;
  logic [NUM_FLOORS-1:0] pending_nxt;
  logic [NUM_FLOORS-1:0] mask_ge;
  logic [NUM_FLOORS-1:0] mask_le;
  logic                  floor_ok;
  logic                  hit_here;
  logic                  hit_ge;
  logic                  hit_le;
  logic [2:0]            low_ge;
  logic [2:0]            high_le;

  assign floor_ok  = (int'(current_floor) < NUM_FLOORS);
  assign call_rise = call_btn & ~btn_hist;
  assign busy      = |pending;

  // An out-of-range floor matches no bit, so it neither clears nor targets anything.
  always_comb begin
    at_floor = '0;
    mask_ge  = '0;
    mask_le  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      at_floor[i] = (int'(current_floor) == i);
      mask_ge[i]  = (i >= int'(current_floor));
      mask_le[i]  = (i <= int'(current_floor));
    end
  end

  assign floor_clr   = door_open ? at_floor : '0;
  assign pending_nxt = (pending | call_rise) & ~floor_clr;
  assign hit_here    = |(pending & at_floor);

  // Nearest pending floor at or above the lift (scan downward so the lowest wins).
  always_comb begin
    hit_ge = 1'b0;
    low_ge = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && mask_ge[i]) begin
        hit_ge = 1'b1;
        low_ge = 3'(i);
      end
    end
  end

  // Nearest pending floor at or below the lift (scan upward so the highest wins).
  always_comb begin
    hit_le  = 1'b0;
    high_le = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && mask_le[i]) begin
        hit_le  = 1'b1;
        high_le = 3'(i);
      end
    end
  end

  // Decisions use the registered pending vector only, so a new call reaches
  // req_floor one cycle after it appears in pending.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_floor;
    if (floor_ok && !door_open) begin
      case (state)
        IDLE: begin
          if (hit_here) begin
            req_nxt = current_floor;
          end else if (hit_ge) begin
            state_nxt = SERVE_UP;
            req_nxt   = low_ge;
          end else if (hit_le) begin
            state_nxt = SERVE_DOWN;
            req_nxt   = high_le;
          end else begin
            req_nxt = current_floor;
          end
        end
        SERVE_UP: begin
          if (hit_ge) begin
            req_nxt = low_ge;
          end else if (hit_le) begin
            state_nxt = SERVE_DOWN;
            req_nxt   = high_le;
          end else begin
            state_nxt = IDLE;
            req_nxt   = current_floor;
          end
        end
        SERVE_DOWN: begin
          if (hit_le) begin
            req_nxt = high_le;
          end else if (hit_ge) begin
            state_nxt = SERVE_UP;
            req_nxt   = low_ge;
          end else begin
            state_nxt = IDLE;
            req_nxt   = current_floor;
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = current_floor;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_floor <= '0;
      dir_up    <= 1'b0;
      dir_down  <= 1'b0;
      pending   <= '0;
      btn_hist  <= '0;
    end else begin
      btn_hist  <= call_btn;
      pending   <= pending_nxt;
      state     <= state_nxt;
      req_floor <= req_nxt;
      dir_up    <= (state_nxt == SERVE_UP);
      dir_down  <= (state_nxt == SERVE_DOWN);
    end
  end

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Bench for lift_request_scheduler: directed scenarios plus randomized traffic
// compared against a floor-list reference model.
module tb_lift_request_scheduler;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] call_btn = '0;
  logic [2:0]   current_floor = '0;
  logic         door_open = 1'b0;
  logic [2:0]   req_floor;
  logic         dir_up;
  logic         dir_down;
  logic [N-1:0] pending;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model: calls as a bit list, travel as -1/0/+1, target as a floor number.
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_hist = '0;
  int           m_dir  = 0;
  int           m_req  = 0;

  lift_request_scheduler #(.NUM_FLOORS(N)) dut (
    .clk(clk), .rst(rst), .call_btn(call_btn), .current_floor(current_floor),
    .door_open(door_open), .req_floor(req_floor), .dir_up(dir_up),
    .dir_down(dir_down), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0;
    m_hist = '0;
    m_dir  = 0;
    m_req  = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] old_p;
    int cf, nearest_up, nearest_down;
    old_p = m_pend;
    cf = int'(current_floor);
    m_pend = m_pend | (call_btn & ~m_hist);
    m_hist = call_btn;
    if (cf < N && door_open) m_pend[cf] = 1'b0;
    if (cf < N && !door_open) begin
      nearest_up = -1;
      for (int f = N - 1; f >= cf; f--) if (old_p[f]) nearest_up = f;
      nearest_down = -1;
      for (int f = 0; f <= cf; f++) if (old_p[f]) nearest_down = f;
      if (m_dir == 0) begin
        if (old_p[cf]) m_req = cf;
        else if (nearest_up >= 0) begin m_dir = 1; m_req = nearest_up; end
        else if (nearest_down >= 0) begin m_dir = -1; m_req = nearest_down; end
        else m_req = cf;
      end else if (m_dir == 1) begin
        if (nearest_up >= 0) m_req = nearest_up;
        else if (nearest_down >= 0) begin m_dir = -1; m_req = nearest_down; end
        else begin m_dir = 0; m_req = cf; end
      end else begin
        if (nearest_down >= 0) m_req = nearest_down;
        else if (nearest_up >= 0) begin m_dir = 1; m_req = nearest_up; end
        else begin m_dir = 0; m_req = cf; end
      end
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (req_floor !== 3'd0) begin errors++; $display("FAIL reset_req: got %0d want 0", req_floor); end
    checks++; if (dir_up !== 1'b0 || dir_down !== 1'b0) begin errors++; $display("FAIL reset_dir: got up=%b down=%b want 0 0", dir_up, dir_down); end
    checks++; if (pending !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b busy=%b want 0", pending, busy); end
    @(negedge clk) rst = 1'b1;
    #1;
  endtask

  task automatic test_first_call();
    current_floor = 3'd0; door_open = 1'b0; call_btn = '0;
    step(); step();
    call_btn = 5'b01000; step();
    checks++; if (pending !== 5'b01000) begin errors++; $display("FAIL call_pending: got %b want 01000", pending); end
    checks++; if (req_floor !== 3'd0 || dir_up !== 1'b0) begin errors++; $display("FAIL call_lag: got req=%0d up=%b want 0 0", req_floor, dir_up); end
    call_btn = '0; step();
    checks++; if (req_floor !== 3'd3 || dir_up !== 1'b1 || dir_down !== 1'b0) begin errors++; $display("FAIL call_target: got req=%0d up=%b down=%b want 3 1 0", req_floor, dir_up, dir_down); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL call_busy: got %b want 1", busy); end
  endtask

  task automatic test_retarget();
    current_floor = 3'd1; step();
    checks++; if (req_floor !== 3'd3) begin errors++; $display("FAIL retarget_pre: got %0d want 3", req_floor); end
    call_btn = 5'b00100; step();
    checks++; if (pending !== 5'b01100 || req_floor !== 3'd3) begin errors++; $display("FAIL retarget_lag: got p=%b req=%0d want 01100 3", pending, req_floor); end
    call_btn = '0; step();
    checks++; if (req_floor !== 3'd2 || dir_up !== 1'b1) begin errors++; $display("FAIL retarget_near: got req=%0d up=%b want 2 1", req_floor, dir_up); end
    current_floor = 3'd2; door_open = 1'b1; step(); step();
    checks++; if (pending !== 5'b01000 || req_floor !== 3'd2 || dir_up !== 1'b1) begin errors++; $display("FAIL retarget_door: got p=%b req=%0d up=%b want 01000 2 1", pending, req_floor, dir_up); end
    door_open = 1'b0; step();
    checks++; if (req_floor !== 3'd3 || dir_up !== 1'b1) begin errors++; $display("FAIL retarget_resume: got req=%0d up=%b want 3 1", req_floor, dir_up); end
    current_floor = 3'd3; door_open = 1'b1; step();
    door_open = 1'b0; step();
    checks++; if (req_floor !== 3'd3 || dir_up !== 1'b0 || dir_down !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL retarget_idle: got req=%0d up=%b down=%b busy=%b want 3 0 0 0", req_floor, dir_up, dir_down, busy); end
  endtask

  task automatic test_up_priority();
    current_floor = 3'd2; step();
    checks++; if (req_floor !== 3'd2) begin errors++; $display("FAIL prio_idle: got %0d want 2", req_floor); end
    call_btn = 5'b10001; step();
    call_btn = '0; step();
    checks++; if (dir_up !== 1'b1 || req_floor !== 3'd4) begin errors++; $display("FAIL prio_up: got up=%b req=%0d want 1 4", dir_up, req_floor); end
    current_floor = 3'd4; door_open = 1'b1; step();
    checks++; if (pending !== 5'b00001 || req_floor !== 3'd4) begin errors++; $display("FAIL prio_serve4: got p=%b req=%0d want 00001 4", pending, req_floor); end
    door_open = 1'b0; step();
    checks++; if (dir_down !== 1'b1 || dir_up !== 1'b0 || req_floor !== 3'd0) begin errors++; $display("FAIL prio_reverse: got down=%b up=%b req=%0d want 1 0 0", dir_down, dir_up, req_floor); end
    current_floor = 3'd0; door_open = 1'b1; step();
    door_open = 1'b0; step();
    checks++; if (dir_down !== 1'b0 || req_floor !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL prio_done: got down=%b req=%0d busy=%b want 0 0 0", dir_down, req_floor, busy); end
  endtask

  task automatic test_clear_and_hold();
    current_floor = 3'd1; door_open = 1'b1; call_btn = 5'b00010; step();
    checks++; if (pending !== 5'b00000) begin errors++; $display("FAIL clear_wins: got %b want 00000", pending); end
    call_btn = 5'b01000;
    for (int k = 0; k < 10; k++) step();
    checks++; if (pending !== 5'b01000) begin errors++; $display("FAIL hold_once: got %b want 01000", pending); end
    door_open = 1'b0; step();
    checks++; if (req_floor !== 3'd3 || dir_up !== 1'b1) begin errors++; $display("FAIL hold_go: got req=%0d up=%b want 3 1", req_floor, dir_up); end
    current_floor = 3'd3; door_open = 1'b1; step();
    door_open = 1'b0; step(); step();
    checks++; if (pending !== 5'b00000 || dir_up !== 1'b0) begin errors++; $display("FAIL hold_norepeat: got p=%b up=%b want 00000 0", pending, dir_up); end
    call_btn = '0; step();
  endtask

  task automatic test_invalid_floor();
    current_floor = 3'd0; call_btn = 5'b00100; step();
    call_btn = '0; step();
    current_floor = 3'd6; door_open = 1'b1; call_btn = 5'b00001; step();
    door_open = 1'b0; call_btn = '0; step();
    checks++; if (pending !== 5'b00101 || req_floor !== 3'd2 || dir_up !== 1'b1) begin errors++; $display("FAIL bad_floor: got p=%b req=%0d up=%b want 00101 2 1", pending, req_floor, dir_up); end
    current_floor = 3'd2; door_open = 1'b1; step();
    current_floor = 3'd0; step();
    door_open = 1'b0; step();
  endtask

  task automatic test_async_reset();
    current_floor = 3'd4; door_open = 1'b0; step();
    call_btn = 5'b00101; step();
    call_btn = '0; step();
    current_floor = 3'd3; call_btn = 5'b10000; step();
    call_btn = '0;
    checks++; if (pending !== 5'b10101 || dir_down !== 1'b1 || req_floor !== 3'd2) begin errors++; $display("FAIL arst_setup: got p=%b down=%b req=%0d want 10101 1 2", pending, dir_down, req_floor); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (pending !== '0 || busy !== 1'b0 || dir_down !== 1'b0 || dir_up !== 1'b0 || req_floor !== 3'd0) begin errors++; $display("FAIL arst_clear: got p=%b busy=%b up=%b down=%b req=%0d want all 0", pending, busy, dir_up, dir_down, req_floor); end
    call_btn = 5'b00010; current_floor = 3'd0;
    @(negedge clk) rst = 1'b1;
    step();
    checks++; if (pending !== 5'b00010) begin errors++; $display("FAIL held_over_reset: got %b want 00010", pending); end
    call_btn = '0; current_floor = 3'd1; door_open = 1'b1; step();
    door_open = 1'b0; current_floor = 3'd3; step(); step();
    checks++; if (req_floor !== 3'd3 || dir_up !== 1'b0 || dir_down !== 1'b0) begin errors++; $display("FAIL arst_idle: got req=%0d up=%b down=%b want 3 0 0", req_floor, dir_up, dir_down); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) call_btn = N'($urandom);
      else if ($urandom_range(0, 1) == 0) call_btn = '0;
      current_floor = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      door_open = ($urandom_range(0, 3) == 0);
      if (k == 700) begin
        #2 rst = 1'b0;
        #1 model_reset();
        @(negedge clk) rst = 1'b1;
      end
      step();
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending[%0d]: got %b want %b", k, pending, m_pend); end
      checks++; if (req_floor !== m_req[2:0]) begin errors++; $display("FAIL rand_req[%0d]: got %0d want %0d", k, req_floor, m_req); end
      checks++; if (dir_up !== (m_dir == 1) || dir_down !== (m_dir == -1)) begin errors++; $display("FAIL rand_dir[%0d]: got up=%b down=%b want dir %0d", k, dir_up, dir_down, m_dir); end
      checks++; if (busy !== (m_pend != '0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", k, busy, (m_pend != '0)); end
    end
  endtask

  initial begin
    test_reset();
    test_first_call();
    test_retarget();
    test_up_priority();
    test_clear_and_hold();
    test_invalid_floor();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
